// File: rtl/uart_tx_frame_arb.sv
// Round-robin frame arbiter in front of a single UART transmitter.
// Latches a 1-4 byte frame from the winner and feeds it out MSB-byte first.
module uart_tx_frame_arb #(
  parameter int BUSY_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [31:0] req0_data,
  input  logic [2:0]  req0_len,
  output logic        req0_ack,
  input  logic        req1_valid,
  input  logic [31:0] req1_data,
  input  logic [2:0]  req1_len,
  output logic        req1_ack,
  output logic        tx_ready,
  output logic [7:0]  tx_data,
  input  logic        tx_busy,
  output logic [1:0]  grant,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, START, WAIT_HI, WAIT_LO} state_t;

  localparam int TW = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [TW-1:0] T_MAX = TW'(BUSY_TIMEOUT - 1);

  state_t          state, state_n;
  logic            last;
  logic [31:0]     shift;
  logic [2:0]      cnt;
  logic [TW-1:0]   tcnt;
  logic            pick0, pick1;
  logic [31:0]     sel_data;
  logic [2:0]      sel_len;

  function automatic logic [2:0] clamp_len(input logic [2:0] len);
    return (len > 3'd4) ? 3'd4 : len;
  endfunction

  // Left-justify the frame so its first byte sits in shift[31:24].
  function automatic logic [31:0] align_frame(input logic [31:0] d, input logic [2:0] lc);
    case (lc)
      3'd1:    return d << 24;
      3'd2:    return d << 16;
      3'd3:    return d << 8;
      3'd4:    return d;
      default: return 32'h0;
    endcase
  endfunction

  assign sel_data = pick1 ? req1_data : req0_data;
  assign sel_len  = clamp_len(pick1 ? req1_len : req0_len);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    pick0   = 1'b0;
    pick1   = 1'b0;
    case (state)
      IDLE: begin
        // Skip the cycle an ack is out so a held valid is not taken twice.
        if (!(req0_ack || req1_ack)) begin
          if (req0_valid && (!req1_valid || last)) pick0 = 1'b1;
          else if (req1_valid)                     pick1 = 1'b1;
        end
        if ((pick0 || pick1) && (sel_len != 3'd0)) state_n = START;
      end
      START:   state_n = WAIT_HI;
      WAIT_HI: if (tx_busy || (tcnt == T_MAX)) state_n = WAIT_LO;
      WAIT_LO: if (!tx_busy) state_n = (cnt != 3'd0) ? START : IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req0_ack <= 1'b0;
      req1_ack <= 1'b0;
      tx_ready <= 1'b0;
      tx_data  <= 8'h00;
      grant    <= 2'b00;
      busy     <= 1'b0;
      last     <= 1'b1;
      shift    <= 32'h0;
      cnt      <= 3'd0;
      tcnt     <= '0;
    end else begin
      req0_ack <= pick0;
      req1_ack <= pick1;
      tx_ready <= (state == START);
      busy     <= (state_n != IDLE);
      case (state)
        IDLE: begin
          if (pick0 || pick1) begin
            grant <= {pick1, pick0};
            last  <= pick1;
            shift <= align_frame(sel_data, sel_len);
            cnt   <= sel_len;
          end else begin
            grant <= 2'b00;
          end
        end
        START: begin
          tx_data <= shift[31:24];
          shift   <= shift << 8;
          cnt     <= cnt - 3'd1;
          tcnt    <= '0;
        end
        WAIT_HI: if (tcnt != T_MAX) tcnt <= tcnt + TW'(1);
        WAIT_LO: if (!tx_busy && (cnt == 3'd0)) grant <= 2'b00;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame_arb.sv
// Directed bench for uart_tx_frame_arb with a simple UART busy model.
module tb_uart_tx_frame_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic [31:0] req0_data, req1_data;
  logic [2:0]  req0_len, req1_len;
  logic        req0_ack, req1_ack;
  logic        tx_ready;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic [1:0]  grant;
  logic        busy;

  int checks = 0;
  int errors = 0;

  int          cyc = 0;
  int          busy_cnt = 0;
  int          uart_mode = 0;
  logic [7:0]  bytes_q[$];
  int          stamp_q[$];
  int          ack0_cnt = 0;
  int          grant_bad = 0;
  logic [1:0]  grant_exp = 2'b01;

  uart_tx_frame_arb #(.BUSY_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_len(req0_len), .req0_ack(req0_ack),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_len(req1_len), .req1_ack(req1_ack),
    .tx_ready(tx_ready), .tx_data(tx_data), .tx_busy(tx_busy),
    .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  // UART model: busy for 10 cycles after each start pulse (mode 0), never busy (mode 1).
  assign tx_busy = (busy_cnt != 0);
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tx_ready && uart_mode == 0) busy_cnt <= 10;
    else if (busy_cnt != 0)         busy_cnt <= busy_cnt - 1;
    if (tx_ready) begin
      bytes_q.push_back(tx_data);
      stamp_q.push_back(cyc);
    end
    if (req0_ack) ack0_cnt <= ack0_cnt + 1;
    if (busy && grant !== grant_exp) grant_bad <= grant_bad + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drop_acks();
    if (req0_ack) req0_valid = 1'b0;
    if (req1_ack) req1_valid = 1'b0;
  endtask

  task automatic raise0(input logic [31:0] d, input logic [2:0] l);
    @(negedge clk);
    req0_data = d; req0_len = l; req0_valid = 1'b1;
  endtask

  task automatic raise1(input logic [31:0] d, input logic [2:0] l);
    @(negedge clk);
    req1_data = d; req1_len = l; req1_valid = 1'b1;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    forever begin
      tick();
      drop_acks();
      if (!busy && !req0_valid && !req1_valid && !req0_ack && !req1_ack) break;
      n++;
      if (n >= budget) begin
        checks++; errors++;
        $display("FAIL %s: no return to idle within %0d cycles", tag, budget);
        req0_valid = 1'b0; req1_valid = 1'b0;
        break;
      end
    end
  endtask

  task automatic wait_bytes(input int target, input string tag);
    int n = 0;
    while (bytes_q.size() < target) begin
      tick();
      drop_acks();
      n++;
      if (n >= 200) begin
        checks++; errors++;
        $display("FAIL %s: byte count %0d, wanted %0d", tag, bytes_q.size(), target);
        break;
      end
    end
  endtask

  task automatic check_byte(input int idx, input logic [7:0] exp, input string tag);
    checks++;
    if (idx >= bytes_q.size()) begin
      errors++;
      $display("FAIL %s: byte %0d missing, wanted %h", tag, idx, exp);
    end else if (bytes_q[idx] !== exp) begin
      errors++;
      $display("FAIL %s: byte %0d got %h wanted %h", tag, idx, bytes_q[idx], exp);
    end
  endtask

  task automatic test_reset();
    repeat (2) tick();
    checks++;
    if ({tx_ready, tx_data, req0_ack, req1_ack, grant, busy} !== 14'h0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b data=%h ack=%b%b grant=%b busy=%b, wanted all 0",
               tx_ready, tx_data, req0_ack, req1_ack, grant, busy);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_tie();
    int base = bytes_q.size();
    @(negedge clk);
    req0_data = 32'h11; req0_len = 3'd1; req0_valid = 1'b1;
    req1_data = 32'h22; req1_len = 3'd1; req1_valid = 1'b1;
    wait_idle(100, "tie1");
    checks++;
    if (bytes_q.size() !== base + 2) begin
      errors++;
      $display("FAIL tie1_count: got %0d bytes wanted 2", bytes_q.size() - base);
    end
    check_byte(base, 8'h11, "tie1_first");
    check_byte(base + 1, 8'h22, "tie1_second");
    base = bytes_q.size();
    raise0(32'h33, 3'd1);
    wait_idle(100, "tie_mid");
    check_byte(base, 8'h33, "tie_mid");
    base = bytes_q.size();
    @(negedge clk);
    req0_data = 32'h11; req0_len = 3'd1; req0_valid = 1'b1;
    req1_data = 32'h22; req1_len = 3'd1; req1_valid = 1'b1;
    wait_idle(100, "tie2");
    check_byte(base, 8'h22, "tie2_first");
    check_byte(base + 1, 8'h11, "tie2_second");
  endtask

  task automatic test_single();
    int base = bytes_q.size();
    int a0 = ack0_cnt;
    int gb = grant_bad;
    grant_exp = 2'b01;
    raise0(32'h0000_0B05, 3'd2);
    tick();
    checks++;
    if (req0_ack !== 1'b1 || grant !== 2'b01) begin
      errors++;
      $display("FAIL single_ack_latency: ack=%b grant=%b wanted 1/01", req0_ack, grant);
    end
    drop_acks();
    tick();
    checks++;
    if (tx_ready !== 1'b1 || tx_data !== 8'h0B) begin
      errors++;
      $display("FAIL single_first_pulse: rdy=%b data=%h wanted 1/0b", tx_ready, tx_data);
    end
    wait_idle(100, "single");
    check_byte(base, 8'h0B, "single_b0");
    check_byte(base + 1, 8'h05, "single_b1");
    checks++;
    if (bytes_q.size() !== base + 2 || ack0_cnt !== a0 + 1) begin
      errors++;
      $display("FAIL single_counts: bytes=%0d acks=%0d wanted 2/1", bytes_q.size() - base, ack0_cnt - a0);
    end
    checks++;
    if (grant_bad !== gb || grant !== 2'b00) begin
      errors++;
      $display("FAIL single_grant: bad_cycles=%0d final=%b wanted 0/00", grant_bad - gb, grant);
    end
  endtask

  task automatic test_long_frame();
    int base = bytes_q.size();
    int ack_bytes = -1;
    logic ack_busy = 1'b1;
    int n = 0;
    raise1(32'hDEAD_BEEF, 3'd4);
    wait_bytes(base + 2, "long_second");
    @(negedge clk);
    req0_data = 32'hA5; req0_len = 3'd1; req0_valid = 1'b1;
    forever begin
      tick();
      if (req0_ack && ack_bytes < 0) begin
        ack_bytes = bytes_q.size() - base;
        ack_busy = tx_busy;
      end
      drop_acks();
      if (!busy && !req0_valid && !req1_valid && !req0_ack && !req1_ack) break;
      n++;
      if (n >= 300) begin
        checks++; errors++;
        $display("FAIL long_idle: no return to idle");
        req0_valid = 1'b0;
        break;
      end
    end
    check_byte(base, 8'hDE, "long_b0");
    check_byte(base + 1, 8'hAD, "long_b1");
    check_byte(base + 2, 8'hBE, "long_b2");
    check_byte(base + 3, 8'hEF, "long_b3");
    check_byte(base + 4, 8'hA5, "long_late");
    checks++;
    if (ack_bytes !== 4 || ack_busy !== 1'b0) begin
      errors++;
      $display("FAIL long_late_ack: ack after %0d bytes busy=%b, wanted 4/0", ack_bytes, ack_busy);
    end
  endtask

  task automatic test_len_edges();
    int base = bytes_q.size();
    int a0 = ack0_cnt;
    grant_exp = 2'b01;
    raise0(32'h55, 3'd0);
    tick();
    checks++;
    if (req0_ack !== 1'b1 || grant !== 2'b01) begin
      errors++;
      $display("FAIL len0_ack: ack=%b grant=%b wanted 1/01", req0_ack, grant);
    end
    drop_acks();
    tick();
    checks++;
    if (grant !== 2'b00 || busy !== 1'b0 || req0_ack !== 1'b0) begin
      errors++;
      $display("FAIL len0_return: grant=%b busy=%b ack=%b wanted 00/0/0", grant, busy, req0_ack);
    end
    repeat (4) tick();
    checks++;
    if (bytes_q.size() !== base || ack0_cnt !== a0 + 1) begin
      errors++;
      $display("FAIL len0_quiet: bytes=%0d acks=%0d wanted 0/1", bytes_q.size() - base, ack0_cnt - a0);
    end
    base = bytes_q.size();
    raise0(32'h0102_0304, 3'd7);
    wait_idle(200, "len7");
    check_byte(base, 8'h01, "len7_b0");
    check_byte(base + 1, 8'h02, "len7_b1");
    check_byte(base + 2, 8'h03, "len7_b2");
    check_byte(base + 3, 8'h04, "len7_b3");
  endtask

  task automatic test_timeout();
    int base = bytes_q.size();
    uart_mode = 1;
    raise0(32'h0000_C3A5, 3'd2);
    wait_idle(100, "timeout");
    check_byte(base, 8'hC3, "timeout_b0");
    check_byte(base + 1, 8'hA5, "timeout_b1");
    checks++;
    if (stamp_q.size() < base + 2 || stamp_q[base + 1] - stamp_q[base] !== 10) begin
      errors++;
      $display("FAIL timeout_spacing: got %0d cycles wanted 10",
               (stamp_q.size() >= base + 2) ? stamp_q[base + 1] - stamp_q[base] : -1);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_busy: busy=%b wanted 0", busy);
    end
    uart_mode = 0;
  endtask

  task automatic test_reset_mid();
    int base = bytes_q.size();
    raise0(32'h000A_0B0C, 3'd3);
    wait_bytes(base + 2, "rst_mid_second");
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({tx_ready, tx_data, req0_ack, req1_ack, grant, busy} !== 14'h0) begin
      errors++;
      $display("FAIL reset_mid_outputs: rdy=%b data=%h ack=%b%b grant=%b busy=%b, wanted all 0",
               tx_ready, tx_data, req0_ack, req1_ack, grant, busy);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    base = bytes_q.size();
    raise0(32'h0000_7788, 3'd2);
    wait_idle(200, "after_reset");
    checks++;
    if (bytes_q.size() !== base + 2) begin
      errors++;
      $display("FAIL after_reset_count: got %0d bytes wanted 2", bytes_q.size() - base);
    end
    check_byte(base, 8'h77, "after_reset_b0");
    check_byte(base + 1, 8'h88, "after_reset_b1");
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req0_data = 32'h0; req0_len = 3'd0;
    req1_valid = 1'b0; req1_data = 32'h0; req1_len = 3'd0;
    test_reset();
    test_tie();
    test_single();
    test_long_frame();
    test_len_edges();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
